counter_axi_core: RTL
=====================

Name: counter_axi_core

Overview:
Counter datapath that sits directly downstream of the Counter_AXI_Register AXI4-Lite slave register file. It consumes the slave's control, load and compare registers plus their write strobes. It runs a prescaled up/down counter with a compare match and optional auto-reload. It returns the live count, a sticky status word and an interrupt; the slave exposes these on its read-back registers.

Parameters:
CNT_W, 32, counter, load and compare width
PRE_W, 16, prescaler divide-value width

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
ctrl_i  in  32  control register: [0] EN, [1] DIR (0 up, 1 down), [2] AUTO_RELOAD, [3] IRQ_EN; other bits ignored
load_i  in  CNT_W  reload/preset value
load_wr_i  in  1  single-cycle pulse: load register written
cmp_i  in  CNT_W  compare value
prescale_i  in  PRE_W  tick period minus 1
status_clr_i  in  1  single-cycle write-one-to-clear pulse
status_clr_mask_i  in  3  sticky bits to clear: [0] MATCH, [1] WRAP, [2] DONE
count_o  out  CNT_W  current count (registered)
status_o  out  32  [0] RUNNING, [1] MATCH, [2] WRAP, [3] DONE, others 0
irq_o  out  1  level interrupt (registered)

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, count_o=0, prescaler=0, status_o=0, irq_o=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN when EN=1. Prescaler is cleared on entry.
  - RUN->IDLE when EN=0. Count holds and the prescaler clears.
  - RUN->DONE on a match tick when AUTO_RELOAD=0.
  - DONE->IDLE when EN=0. DONE holds while EN=1.
- Prescaler:
  - Counts only in RUN. It issues a tick when pcnt==prescale_i, then pcnt<=0.
  - prescale_i=0 gives a tick every RUN cycle.
  - A prescale_i change takes effect at the next comparison.
- Latency: EN is sampled at edge k in IDLE. The first count change is registered at edge k+prescale_i+1.
- On each tick in RUN:
  - If count==cmp_i: set MATCH. Then count<=load_i if AUTO_RELOAD=1 (stay in RUN), else count holds and the FSM goes to DONE with DONE set.
  - Else: count<=count+1 (DIR=0) or count-1 (DIR=1), modulo 2^CNT_W.
  - Wrap: up from all-ones to 0, or down from 0 to all-ones, sets WRAP.
- load_wr_i:
  - count<=load_i in any state.
  - It has priority over a same-cycle tick, and that tick does no compare or increment.
  - The prescaler is not disturbed.
- RUNNING bit = (state==RUN), combinational from the state register.
- Sticky bits:
  - A sticky bit is cleared by status_clr_i with its mask bit set.
  - A same-cycle set beats clear.
  - Clearing DONE does not change the FSM state.
- irq_o <= IRQ_EN & (MATCH | WRAP | DONE), one cycle after the sticky update. Deasserting IRQ_EN drops irq_o on the next edge without clearing the sticky bits.
- DIR or AUTO_RELOAD changes mid-run apply at the next tick.
- Reset mid-run returns every output to its reset value immediately.

Decomposition:
- Package counter_axi_pkg:
  - state enum (IDLE, RUN, DONE);
  - ctrl bit-index constants (CTRL_EN=0, CTRL_DIR=1, CTRL_AR=2, CTRL_IRQEN=3);
  - status bit-index constants;
  - clear-mask bit constants.
- One sub-module, counter_axi_prescaler: PRE_W counter with enable, synchronous clear and tick output. Everything else stays in counter_axi_core.

Test Plan:
- Basic up count: load 0, cmp=5, prescale=0, ctrl=0x1 -> count_o goes 1..5 on consecutive cycles; MATCH and DONE set on the tick after count=5; state DONE; count holds 5; irq_o=0.
- Prescale and down count: load=3, prescale=2, ctrl=0x3, cmp=0x10 -> count changes every 3 cycles: 3,2,1,0 then 0xFFFFFFFF; WRAP=1; counting continues.
- Auto-reload with IRQ: load=2, cmp=4, ctrl=0xD -> sequence 2,3,4,2,3,4...; MATCH set; irq_o=1 one cycle after MATCH; never enters DONE.
- Set/clear collision: status_clr_i with mask=0b001 on the same cycle as a match tick -> MATCH stays 1. Clear on a later idle cycle -> MATCH=0, and irq_o drops the next cycle if no other sticky bit is set.
- load_wr_i during a tick: running up at count=7, pulse load_wr_i with load_i=0x100 on a tick cycle -> count_o=0x100, no increment that cycle, next tick gives 0x101.
- Reset mid-run: assert S_AXI_ARESETN=0 while count=0x20 in RUN -> count_o=0, status_o=0 and irq_o=0 asynchronously; after release with EN still 1, the block restarts from 0.

Source files
------------

// File: rtl/counter_axi_pkg.sv
// counter_axi_pkg
// Shared types and bit positions for the counter datapath behind the
// Counter_AXI_Register slave: FSM state encoding, control-register fields,
// status-word fields and write-one-to-clear mask fields.
package counter_axi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    // Control register fields
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_DIR   = 1;
    localparam int unsigned CTRL_AR    = 2;
    localparam int unsigned CTRL_IRQEN = 3;

    // Status word fields
    localparam int unsigned STS_RUNNING = 0;
    localparam int unsigned STS_MATCH   = 1;
    localparam int unsigned STS_WRAP    = 2;
    localparam int unsigned STS_DONE    = 3;

    // Clear-mask fields
    localparam int unsigned CLR_MATCH = 0;
    localparam int unsigned CLR_WRAP  = 1;
    localparam int unsigned CLR_DONE  = 2;

endpackage

// File: rtl/counter_axi_prescaler.sv
// counter_axi_prescaler
// Divides the clock by (prescale + 1) while enabled and emits a one-cycle tick.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          count enable; tick is only issued while enabled
//   clr         synchronous clear of the divider count (wins over en)
//   prescale    tick period minus 1, compared live every cycle
//   tick        high in the cycle the divider count equals prescale
module counter_axi_prescaler #(
    parameter int unsigned PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pcnt_q;

    assign tick = en && (pcnt_q == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (clr || tick) begin
            pcnt_q <= '0;
        end else if (en) begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/counter_axi_core.sv
// counter_axi_core
// Prescaled up/down counter with compare match, optional auto-reload, sticky
// status and a level interrupt, fed by the AXI4-Lite register slave.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock and asynchronous active-low reset
//   ctrl_i              [0] EN, [1] DIR (1 = down), [2] AUTO_RELOAD, [3] IRQ_EN
//   load_i, load_wr_i   preset value and its write pulse (loads in any state)
//   cmp_i               compare value
//   prescale_i          tick period minus 1
//   status_clr_i        write-one-to-clear pulse, qualified by status_clr_mask_i
//   count_o             registered count
//   status_o            [0] RUNNING, [1] MATCH, [2] WRAP, [3] DONE
//   irq_o               registered level interrupt
module counter_axi_core
    import counter_axi_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRE_W = 16
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic [31:0]      ctrl_i,
    input  logic [CNT_W-1:0] load_i,
    input  logic             load_wr_i,
    input  logic [CNT_W-1:0] cmp_i,
    input  logic [PRE_W-1:0] prescale_i,
    input  logic             status_clr_i,
    input  logic [2:0]       status_clr_mask_i,
    output logic [CNT_W-1:0] count_o,
    output logic [31:0]      status_o,
    output logic             irq_o
);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             match_q, wrap_q, done_q, irq_q;
    logic             match_d, wrap_d, done_d;

    logic en, dir, auto_reload, irq_en;
    logic running, tick, run_tick, hit;
    logic set_match, set_wrap, set_done;
    logic unused_ctrl;

    assign en          = ctrl_i[CTRL_EN];
    assign dir         = ctrl_i[CTRL_DIR];
    assign auto_reload = ctrl_i[CTRL_AR];
    assign irq_en      = ctrl_i[CTRL_IRQEN];
    assign unused_ctrl = ^ctrl_i[31:4];

    assign running = (state_q == StRun);

    // Held cleared outside RUN so it restarts from zero on every entry, and
    // cleared on the exit cycle so a stopped run leaves no partial period.
    counter_axi_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .en       (running),
        .clr      (!running || !en),
        .prescale (prescale_i),
        .tick     (tick)
    );

    always_comb begin
        // A load write swallows a coincident tick entirely.
        run_tick  = tick && en && !load_wr_i;
        hit       = run_tick && (count_q == cmp_i);
        set_match = hit;
        set_done  = hit && !auto_reload;
        set_wrap  = run_tick && !hit && (dir ? (count_q == '0) : (&count_q));
        // Set beats a same-cycle clear.
        match_d = set_match | (match_q & ~(status_clr_i & status_clr_mask_i[CLR_MATCH]));
        wrap_d  = set_wrap  | (wrap_q  & ~(status_clr_i & status_clr_mask_i[CLR_WRAP]));
        done_d  = set_done  | (done_q  & ~(status_clr_i & status_clr_mask_i[CLR_DONE]));
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= StIdle;
            count_q <= '0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            match_q <= match_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            // Follows the registered sticky bits, so it lags them by a cycle.
            irq_q   <= irq_en & (match_q | wrap_q | done_q);

            if (load_wr_i) begin
                count_q <= load_i;
            end else if (run_tick) begin
                if (hit) begin
                    if (auto_reload) begin
                        count_q <= load_i;
                    end
                end else if (dir) begin
                    count_q <= count_q - 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: if (en) state_q <= StRun;
                StRun: begin
                    if (!en) begin
                        state_q <= StIdle;
                    end else if (set_done) begin
                        state_q <= StDone;
                    end
                end
                StDone: if (!en) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        status_o              = '0;
        status_o[STS_RUNNING] = running;
        status_o[STS_MATCH]   = match_q;
        status_o[STS_WRAP]    = wrap_q;
        status_o[STS_DONE]    = done_q;
    end

    assign count_o = count_q;
    assign irq_o   = irq_q;

endmodule
